wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback stage plus architectural register file of the 5-stage pipeline. Consumes the MA/WB pipeline-register outputs and selects the writeback value (ALU result, load data, immediate or link address). Commits that value to a 32x32 register file and serves the two ID-stage read ports with same-cycle write-to-read bypass. Also keeps a retired-writeback counter and a debug read port for the bench.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register index width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
clkIn  input  1  pipeline clock, all state updates on rising edge
resetIn  input  1  asynchronous, active-low reset
ctrSignalsIn  input  3  from MA/WB: [0] RegWrite, [2:1] WBSel
ResultIn  input  DATA_W  ALU result from MA/WB
Imm32In  input  DATA_W  extended immediate from MA/WB
DataIn  input  DATA_W  load data from MA/WB
AddrIn  input  DATA_W  link address (PC+4) from MA/WB
rdIn  input  ADDR_W  destination register from MA/WB
rs1In  input  ADDR_W  ID-stage source index 1
rs2In  input  ADDR_W  ID-stage source index 2
dbgAddrIn  input  ADDR_W  bench/debug read index
rs1DataOut  output  DATA_W  register rs1 value, bypassed
rs2DataOut  output  DATA_W  register rs2 value, bypassed
wbDataOut  output  DATA_W  selected writeback value, for forwarding to EX
dbgDataOut  output  DATA_W  register dbgAddrIn value, not bypassed
wbCountOut  output  32  number of committed register writes

Behaviour:
- Clock and reset: one clock, clkIn. resetIn is asynchronous and active-low. While resetIn=0, all NREG registers and wbCountOut are 0, regardless of clock.
- WBSel decode is combinational: 00 -> ResultIn, 01 -> DataIn, 10 -> Imm32In, 11 -> AddrIn. The result drives wbDataOut whether or not RegWrite is set.
- Commit condition: commit = RegWrite & (rdIn != 0).
- On posedge with commit, reg[rdIn] <= wbDataOut and wbCountOut <= wbCountOut + 1. The counter wraps from 0xFFFFFFFF to 0.
- Without commit, no register or counter changes.
- Register 0 is hardwired to zero. Writes to index 0 are dropped and do not increment wbCountOut.
- Read ports rs1 and rs2 are combinational, zero latency:
  - index 0 -> 0
  - else if commit and rdIn == rsX -> wbDataOut (write-before-read bypass, so ID sees the value committing this cycle)
  - else reg[rsX]
- rs1In == rs2In == rdIn with commit: both ports return wbDataOut.
- dbgDataOut = reg[dbgAddrIn]. It shows post-edge state only (no bypass); index 0 reads 0.
- Write latency: a value is visible on dbgDataOut one cycle after the commit edge. It is visible on rs ports in the same cycle via bypass.
- Reset asserted mid-operation: pending write is discarded, all state clears immediately. The first commit after release behaves normally.
- No stall input. MA/WB presents a bubble as ctrSignalsIn = 0, which is a no-op.

Decomposition:
- Shared package pipe_pkg holds:
  - WBSel encodings (WB_RESULT=2'b00, WB_DATA=2'b01, WB_IMM=2'b10, WB_LINK=2'b11)
  - ctrSignals bit indices (CTR_REGWRITE=0, CTR_WBSEL_LO=1, CTR_WBSEL_HI=2)
  - DATA_W/ADDR_W defaults, shared with the MA/WB and EX/MA registers.
- One combinational sub-module, wb_mux (4:1 writeback select), instantiated once in wb_regfile. The bypassing register array stays in the top module.

Test Plan:
- Reset: assert resetIn=0 asynchronously mid-cycle after writes -> all dbg reads 0 and wbCountOut=0 immediately, before the next edge.
- Select and commit: ctr=3'b001, rd=5, ResultIn=0x1234 -> after edge dbg[5]=0x1234, wbCountOut=1. Repeat with WBSel=01/10/11 on rd=6/7/8 -> DataIn/Imm32In/AddrIn stored respectively.
- x0 protection: ctr=3'b001, rd=0, ResultIn=0xDEAD -> rs1In=0 reads 0, dbg[0]=0, wbCountOut unchanged.
- Bypass:
  - reg[3]=0x11, then commit 0x22 to rd=3 with rs1In=rs2In=3 -> both ports read 0x22 before the edge, dbg[3]=0x11 before the edge and 0x22 after.
  - Same transaction with RegWrite=0 -> ports read 0x11.
- Counter wrap: preload via 2^32-1 commits (or force) -> next commit makes wbCountOut=0. Bubbles (ctr=0) leave it unchanged.
- Reset mid-write: commit 0x55 to rd=9 with resetIn falling before the edge -> dbg[9]=0 after release, and the next commit of 0x66 lands normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, MA/WB control encodings and
// the operand bundle feeding the writeback select.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 2 ** ADDR_W;
    localparam int unsigned CTR_W  = 3;
    localparam int unsigned CNT_W  = 32;

    // Bit positions inside ctrSignalsIn
    localparam int unsigned CTR_REGWRITE = 0;
    localparam int unsigned CTR_WBSEL_LO = 1;
    localparam int unsigned CTR_WBSEL_HI = 2;

    typedef enum logic [1:0] {
        WB_RESULT = 2'b00,
        WB_DATA   = 2'b01,
        WB_IMM    = 2'b10,
        WB_LINK   = 2'b11
    } wb_sel_e;

    // Candidate writeback values presented by MA/WB
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] imm32;
        logic [DATA_W-1:0] link;
    } wb_src_t;

    // Extract the writeback select field from the control word
    function automatic wb_sel_e ctr_wbsel(input logic [CTR_W-1:0] ctr);
        return wb_sel_e'(ctr[CTR_WBSEL_HI:CTR_WBSEL_LO]);
    endfunction

    // A write commits only when RegWrite is set and the target is not x0
    function automatic logic ctr_commit(input logic [CTR_W-1:0]  ctr,
                                        input logic [ADDR_W-1:0] rd);
        return ctr[CTR_REGWRITE] && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MA/WB-to-writeback and ID read-port bundle for the register file.
interface wb_regfile_if;
    import pipe_pkg::*;

    logic [CTR_W-1:0]  ctrSignalsIn;
    logic [DATA_W-1:0] ResultIn;
    logic [DATA_W-1:0] Imm32In;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] AddrIn;
    logic [ADDR_W-1:0] rdIn;
    logic [ADDR_W-1:0] rs1In;
    logic [ADDR_W-1:0] rs2In;
    logic [ADDR_W-1:0] dbgAddrIn;
    logic [DATA_W-1:0] rs1DataOut;
    logic [DATA_W-1:0] rs2DataOut;
    logic [DATA_W-1:0] wbDataOut;
    logic [DATA_W-1:0] dbgDataOut;
    logic [CNT_W-1:0]  wbCountOut;

    // Pipeline side: drives MA/WB fields and ID read indices
    modport master (
        output ctrSignalsIn, ResultIn, Imm32In, DataIn, AddrIn,
        output rdIn, rs1In, rs2In, dbgAddrIn,
        input  rs1DataOut, rs2DataOut, wbDataOut, dbgDataOut, wbCountOut
    );

    // Register file side
    modport slave (
        input  ctrSignalsIn, ResultIn, Imm32In, DataIn, AddrIn,
        input  rdIn, rs1In, rs2In, dbgAddrIn,
        output rs1DataOut, rs2DataOut, wbDataOut, dbgDataOut, wbCountOut
    );

endinterface

// File: rtl/wb_mux.sv
// 4:1 writeback value select, purely combinational.
module wb_mux
    import pipe_pkg::*;
(
    input  wb_sel_e           sel,
    input  wb_src_t           src,
    output logic [DATA_W-1:0] wb_data
);

    // Pick the source named by WBSel
    always_comb begin
        wb_data = src.result;
        unique case (sel)
            WB_RESULT: wb_data = src.result;
            WB_DATA:   wb_data = src.data;
            WB_IMM:    wb_data = src.imm32;
            WB_LINK:   wb_data = src.link;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file with write-to-read
// bypass on both ID ports, a retired-write counter and a debug read port.
module wb_regfile
    import pipe_pkg::*;
(
    input  logic         clkIn,
    input  logic         resetIn,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  wb_count;
    logic              commit;
    wb_sel_e           wb_sel;
    wb_src_t           wb_src;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] dbg_data;

    assign wb_sel = ctr_wbsel(bus.ctrSignalsIn);
    assign commit = ctr_commit(bus.ctrSignalsIn, bus.rdIn);

    assign wb_src = '{
        result: bus.ResultIn,
        data:   bus.DataIn,
        imm32:  bus.Imm32In,
        link:   bus.AddrIn
    };

    wb_mux u_wb_mux (
        .sel     (wb_sel),
        .src     (wb_src),
        .wb_data (wb_data)
    );

    // Register array; x0 is cleared by reset and never written
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.rdIn] <= wb_data;
        end
    end

    // Count committed writes, wrapping naturally at full scale
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            wb_count <= '0;
        end else if (commit) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

    // rs1 read: x0 reads zero, otherwise the committing value wins over the array
    always_comb begin
        rs1_data = regs[bus.rs1In];
        if (bus.rs1In == '0) begin
            rs1_data = '0;
        end else if (commit && (bus.rdIn == bus.rs1In)) begin
            rs1_data = wb_data;
        end
    end

    // rs2 read: same bypass rule as rs1
    always_comb begin
        rs2_data = regs[bus.rs2In];
        if (bus.rs2In == '0) begin
            rs2_data = '0;
        end else if (commit && (bus.rdIn == bus.rs2In)) begin
            rs2_data = wb_data;
        end
    end

    // Debug read shows stored state only, no bypass
    always_comb begin
        dbg_data = regs[bus.dbgAddrIn];
        if (bus.dbgAddrIn == '0) begin
            dbg_data = '0;
        end
    end

    assign bus.wbDataOut  = wb_data;
    assign bus.rs1DataOut = rs1_data;
    assign bus.rs2DataOut = rs2_data;
    assign bus.dbgDataOut = dbg_data;
    assign bus.wbCountOut = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, mid-write reset and
// counter-wrap sequences.
module tb_wb_regfile;

    logic clk;
    logic rst_n;

    wb_regfile_if bus();

    wb_regfile dut (
        .clkIn   (clk),
        .resetIn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] result;
        logic [31:0] e_wb;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_pre;
        logic [31:0] e_post;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 12;
    localparam logic [31:0] DATA_V = 32'hAAAA_0001;
    localparam logic [31:0] IMM_V  = 32'hBBBB_0002;
    localparam logic [31:0] LINK_V = 32'hCCCC_0003;

    vec_t vecs [NVEC];
    int   n_vec;
    int   n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ctr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] dbg, input logic [31:0] result);
        bus.ctrSignalsIn = ctr;
        bus.rdIn         = rd;
        bus.rs1In        = rs1;
        bus.rs2In        = rs2;
        bus.dbgAddrIn    = dbg;
        bus.ResultIn     = result;
        bus.DataIn       = DATA_V;
        bus.Imm32In      = IMM_V;
        bus.AddrIn       = LINK_V;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // ctr, rd, rs1, rs2, dbg, result, wb, rs1, rs2, dbg_pre, dbg_post, count
        vecs[0]  = '{3'b001, 5'd5,  5'd5,  5'd0, 5'd5,  32'h1234,      32'h1234,      32'h1234,      32'h0,         32'h0,    32'h1234,      32'd1};
        vecs[1]  = '{3'b011, 5'd6,  5'd5,  5'd6, 5'd6,  32'h0,         DATA_V,        32'h1234,      DATA_V,        32'h0,    DATA_V,        32'd2};
        vecs[2]  = '{3'b101, 5'd7,  5'd6,  5'd7, 5'd7,  32'h0,         IMM_V,         DATA_V,        IMM_V,         32'h0,    IMM_V,         32'd3};
        vecs[3]  = '{3'b111, 5'd8,  5'd8,  5'd7, 5'd8,  32'h0,         LINK_V,        LINK_V,        IMM_V,         32'h0,    LINK_V,        32'd4};
        vecs[4]  = '{3'b001, 5'd0,  5'd0,  5'd0, 5'd0,  32'hDEAD,      32'hDEAD,      32'h0,         32'h0,         32'h0,    32'h0,         32'd4};
        vecs[5]  = '{3'b001, 5'd3,  5'd3,  5'd3, 5'd3,  32'h11,        32'h11,        32'h11,        32'h11,        32'h0,    32'h11,        32'd5};
        vecs[6]  = '{3'b000, 5'd3,  5'd3,  5'd3, 5'd3,  32'h22,        32'h22,        32'h11,        32'h11,        32'h11,   32'h11,        32'd5};
        vecs[7]  = '{3'b001, 5'd3,  5'd3,  5'd3, 5'd3,  32'h22,        32'h22,        32'h22,        32'h22,        32'h11,   32'h22,        32'd6};
        vecs[8]  = '{3'b110, 5'd4,  5'd4,  5'd8, 5'd4,  32'h0,         LINK_V,        32'h0,         LINK_V,        32'h0,    32'h0,         32'd6};
        vecs[9]  = '{3'b000, 5'd0,  5'd5,  5'd3, 5'd5,  32'h0,         32'h0,         32'h1234,      32'h22,        32'h1234, 32'h1234,      32'd6};
        vecs[10] = '{3'b001, 5'd31, 5'd31, 5'd5, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234,      32'h0,    32'hFFFF_FFFF, 32'd7};
        vecs[11] = '{3'b001, 5'd9,  5'd8,  5'd9, 5'd9,  32'h99,        32'h99,        LINK_V,        32'h99,        32'h0,    32'h99,        32'd8};

        // Power-on reset, checked while held low
        rst_n = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd5, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_count", bus.wbCountOut, 32'd0);
        check("reset_dbg5", bus.dbgDataOut, 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].ctr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].dbg, vecs[i].result);
            #1;
            check($sformatf("v%0d_wb", i),      bus.wbDataOut,  vecs[i].e_wb);
            check($sformatf("v%0d_rs1", i),     bus.rs1DataOut, vecs[i].e_rs1);
            check($sformatf("v%0d_rs2", i),     bus.rs2DataOut, vecs[i].e_rs2);
            check($sformatf("v%0d_dbg_pre", i), bus.dbgDataOut, vecs[i].e_pre);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_dbg_post", i), bus.dbgDataOut, vecs[i].e_post);
            check($sformatf("v%0d_count", i),    bus.wbCountOut, vecs[i].e_cnt);
        end

        // Reset falling mid-write: pending commit to x9 discarded, all state clears at once
        @(negedge clk);
        drive(3'b001, 5'd9, 5'd9, 5'd0, 5'd9, 32'h55);
        #1;
        check("midrst_bypass", bus.rs1DataOut, 32'h55);
        check("midrst_dbg9_pre", bus.dbgDataOut, 32'h99);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_count", bus.wbCountOut, 32'd0);
        check("midrst_dbg9", bus.dbgDataOut, 32'd0);
        for (int r = 1; r < 32; r++) begin
            bus.dbgAddrIn = 5'(r);
            #1;
            check($sformatf("midrst_dbg%0d", r), bus.dbgDataOut, 32'd0);
        end
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd9, 32'h0);
        rst_n = 1'b1;
        #1;
        check("release_dbg9", bus.dbgDataOut, 32'd0);
        check("release_count", bus.wbCountOut, 32'd0);
        @(negedge clk);
        drive(3'b001, 5'd9, 5'd9, 5'd9, 5'd9, 32'h66);
        #1;
        check("post_rst_rs1", bus.rs1DataOut, 32'h66);
        check("post_rst_rs2", bus.rs2DataOut, 32'h66);
        @(posedge clk);
        #1;
        check("post_rst_dbg9", bus.dbgDataOut, 32'h66);
        check("post_rst_count", bus.wbCountOut, 32'd1);

        // Counter wrap: preload to full scale, bubble holds it, next commit wraps
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        #1;
        check("wrap_preload", bus.wbCountOut, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("wrap_bubble", bus.wbCountOut, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 32'h7);
        @(posedge clk);
        #1;
        check("wrap_x0_hold", bus.wbCountOut, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(3'b001, 5'd10, 5'd0, 5'd0, 5'd10, 32'h77);
        @(posedge clk);
        #1;
        check("wrap_zero", bus.wbCountOut, 32'd0);
        check("wrap_dbg10", bus.dbgDataOut, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
